// File: rtl/demux_1_4_buf_if.sv
// Stream bundle for the 1-to-4 demultiplexer: one producer-facing input stream,
// four consumer-facing output streams and the per-channel delivery counters.
interface demux_1_4_buf_if #(
   parameter int W     = 4,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_data;
   logic [1:0]       in_sel;

   logic             out_valid_0;
   logic             out_valid_1;
   logic             out_valid_2;
   logic             out_valid_3;
   logic             out_ready_0;
   logic             out_ready_1;
   logic             out_ready_2;
   logic             out_ready_3;
   logic [W-1:0]     out_data_0;
   logic [W-1:0]     out_data_1;
   logic [W-1:0]     out_data_2;
   logic [W-1:0]     out_data_3;

   logic [CNT_W-1:0] cnt_0;
   logic [CNT_W-1:0] cnt_1;
   logic [CNT_W-1:0] cnt_2;
   logic [CNT_W-1:0] cnt_3;

   modport slave (
      input  in_valid, in_data, in_sel,
      input  out_ready_0, out_ready_1, out_ready_2, out_ready_3,
      output in_ready,
      output out_valid_0, out_valid_1, out_valid_2, out_valid_3,
      output out_data_0, out_data_1, out_data_2, out_data_3,
      output cnt_0, cnt_1, cnt_2, cnt_3
   );

   modport master (
      output in_valid, in_data, in_sel,
      output out_ready_0, out_ready_1, out_ready_2, out_ready_3,
      input  in_ready,
      input  out_valid_0, out_valid_1, out_valid_2, out_valid_3,
      input  out_data_0, out_data_1, out_data_2, out_data_3,
      input  cnt_0, cnt_1, cnt_2, cnt_3
   );
endinterface

// File: rtl/demux_1_4_buf.sv
// Registered 1-to-4 stream demultiplexer with a one-entry buffer and a
// wrapping delivery counter per channel; channels stall independently.
module demux_1_4_buf #(
   parameter int W     = 4,
   parameter int CNT_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   demux_1_4_buf_if.slave  bus
);
   logic [3:0]       w_out_ready;
   logic             w_in_ready;
   logic             w_in_xfer  [4];
   logic             w_out_xfer [4];

   logic             r_full [4];
   logic [W-1:0]     r_data [4];
   logic [CNT_W-1:0] r_cnt  [4];

   assign w_out_ready = {bus.out_ready_3, bus.out_ready_2, bus.out_ready_1, bus.out_ready_0};

   // Selected buffer accepts when empty or when it drains in this same cycle.
   assign w_in_ready   = !rst && (!r_full[bus.in_sel] || w_out_ready[bus.in_sel]);
   assign bus.in_ready = w_in_ready;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_ch
         assign w_in_xfer[gi]  = bus.in_valid && w_in_ready && (bus.in_sel == 2'(gi));
         assign w_out_xfer[gi] = r_full[gi] && w_out_ready[gi];

         always_ff @(posedge clk) begin
            if (rst) begin
               r_full[gi] <= 1'b0;
               r_data[gi] <= '0;
               r_cnt[gi]  <= '0;
            end else begin
               // A reload wins over a drain so back-to-back words keep the buffer full.
               if (w_in_xfer[gi]) begin
                  r_data[gi] <= bus.in_data;
                  r_full[gi] <= 1'b1;
               end else if (w_out_xfer[gi]) begin
                  r_full[gi] <= 1'b0;
               end
               if (w_out_xfer[gi]) begin
                  r_cnt[gi] <= r_cnt[gi] + CNT_W'(1);
               end
            end
         end
      end
   endgenerate

   assign bus.out_valid_0 = r_full[0];
   assign bus.out_valid_1 = r_full[1];
   assign bus.out_valid_2 = r_full[2];
   assign bus.out_valid_3 = r_full[3];
   assign bus.out_data_0  = r_data[0];
   assign bus.out_data_1  = r_data[1];
   assign bus.out_data_2  = r_data[2];
   assign bus.out_data_3  = r_data[3];
   assign bus.cnt_0       = r_cnt[0];
   assign bus.cnt_1       = r_cnt[1];
   assign bus.cnt_2       = r_cnt[2];
   assign bus.cnt_3       = r_cnt[3];
endmodule

// File: tb/tb_demux_1_4_buf.sv
// Directed bench for demux_1_4_buf: a default-width instance for routing, stall,
// streaming and reset cases, plus a CNT_W=4 instance for counter wrap.
module tb_demux_1_4_buf;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   demux_1_4_buf_if #(.W(4), .CNT_W(8)) bus ();
   demux_1_4_buf_if #(.W(4), .CNT_W(4)) bus_w ();

   demux_1_4_buf #(.W(4), .CNT_W(8)) u_dut (.clk(clk), .rst(rst), .bus(bus));
   demux_1_4_buf #(.W(4), .CNT_W(4)) u_dut_w (.clk(clk), .rst(rst), .bus(bus_w));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end else begin
         $display("  ok   %s = 0x%0h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rd_valid(input int k);
      case (k)
         0:       return 32'(bus.out_valid_0);
         1:       return 32'(bus.out_valid_1);
         2:       return 32'(bus.out_valid_2);
         default: return 32'(bus.out_valid_3);
      endcase
   endfunction

   function automatic logic [31:0] rd_data(input int k);
      case (k)
         0:       return 32'(bus.out_data_0);
         1:       return 32'(bus.out_data_1);
         2:       return 32'(bus.out_data_2);
         default: return 32'(bus.out_data_3);
      endcase
   endfunction

   function automatic logic [31:0] rd_cnt(input int k);
      case (k)
         0:       return 32'(bus.cnt_0);
         1:       return 32'(bus.cnt_1);
         2:       return 32'(bus.cnt_2);
         default: return 32'(bus.cnt_3);
      endcase
   endfunction

   task automatic set_ready(input logic [3:0] rdy);
      bus.out_ready_0 = rdy[0];
      bus.out_ready_1 = rdy[1];
      bus.out_ready_2 = rdy[2];
      bus.out_ready_3 = rdy[3];
   endtask

   task automatic check_all(input string tag, input logic [31:0] v, input logic [31:0] d,
                            input logic [31:0] c);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("%s valid_%0d", tag, k), rd_valid(k), v);
         check($sformatf("%s data_%0d", tag, k), rd_data(k), d);
         check($sformatf("%s cnt_%0d", tag, k), rd_cnt(k), c);
      end
   endtask

   task automatic send(input logic [1:0] sel, input logic [3:0] data);
      bus.in_valid = 1'b1;
      bus.in_sel   = sel;
      bus.in_data  = data;
   endtask

   logic [3:0] vals [4];

   initial begin
      vals[0] = 4'h3; vals[1] = 4'h5; vals[2] = 4'hA; vals[3] = 4'hC;
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_sel = 2'd0; bus.in_data = 4'h0;
      set_ready(4'b0000);
      bus_w.in_valid = 1'b0; bus_w.in_sel = 2'd1; bus_w.in_data = 4'h0;
      bus_w.out_ready_0 = 1'b0; bus_w.out_ready_1 = 1'b1;
      bus_w.out_ready_2 = 1'b0; bus_w.out_ready_3 = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst in_ready", 32'(bus.in_ready), 0);
      check_all("rst", 0, 0, 0);
      rst = 1'b0;
      #1;
      check("post-rst in_ready", 32'(bus.in_ready), 1);

      // One word per channel, all consumers ready
      set_ready(4'b1111);
      for (int k = 0; k < 4; k++) begin
         send(2'(k), vals[k]);
         #1;
         check($sformatf("route%0d in_ready", k), 32'(bus.in_ready), 1);
         tick();
         check($sformatf("route%0d valid", k), rd_valid(k), 1);
         check($sformatf("route%0d data", k), rd_data(k), 32'(vals[k]));
         if (k > 0) check($sformatf("route%0d prev drained", k), rd_valid(k - 1), 0);
      end
      bus.in_valid = 1'b0;
      tick();
      for (int k = 0; k < 4; k++) begin
         check($sformatf("route cnt_%0d", k), rd_cnt(k), 1);
         check($sformatf("route idle valid_%0d", k), rd_valid(k), 0);
      end

      // Stall channel 2, other channels keep flowing
      set_ready(4'b1011);
      send(2'd2, 4'h7);
      #1;
      check("stall w7 in_ready", 32'(bus.in_ready), 1);
      tick();
      check("stall ch2 data", rd_data(2), 32'h7);
      send(2'd0, 4'h1);
      #1;
      check("bypass in_ready", 32'(bus.in_ready), 1);
      tick();
      check("bypass ch0 valid", rd_valid(0), 1);
      check("bypass ch0 data", rd_data(0), 32'h1);
      check("bypass ch2 valid", rd_valid(2), 1);
      check("bypass ch2 data", rd_data(2), 32'h7);
      send(2'd2, 4'h9);
      #1;
      check("stall w9 in_ready", 32'(bus.in_ready), 0);
      tick();
      check("stall held in_ready", 32'(bus.in_ready), 0);
      check("stall held data", rd_data(2), 32'h7);
      check("stall cnt_2", rd_cnt(2), 1);
      check("bypass cnt_0", rd_cnt(0), 2);
      bus.out_ready_2 = 1'b1;
      #1;
      check("release in_ready", 32'(bus.in_ready), 1);
      tick();
      check("release ch2 valid", rd_valid(2), 1);
      check("release ch2 data", rd_data(2), 32'h9);
      check("release cnt_2", rd_cnt(2), 2);
      bus.in_valid = 1'b0;
      tick();
      check("drain ch2 valid", rd_valid(2), 0);
      check("drain ch2 data kept", rd_data(2), 32'h9);
      check("drain cnt_2", rd_cnt(2), 3);

      // Fresh reset, then stream 16 words to channel 3
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_ready(4'b1111);
      for (int i = 0; i < 16; i++) begin
         send(2'd3, 4'(15 - i));
         #1;
         check($sformatf("stream%0d in_ready", i), 32'(bus.in_ready), 1);
         tick();
         check($sformatf("stream%0d data", i), rd_data(3), 32'(15 - i));
      end
      bus.in_valid = 1'b0;
      tick();
      check("stream cnt_3", rd_cnt(3), 16);
      check("stream valid_3", rd_valid(3), 0);

      // Counter wrap on the narrow instance
      for (int i = 0; i < 17; i++) begin
         bus_w.in_valid = 1'b1;
         bus_w.in_data  = 4'(i);
         tick();
         if (i == 15) check("wrap cnt_1 at 15", 32'(bus_w.cnt_1), 15);
      end
      bus_w.in_valid = 1'b0;
      tick();
      check("wrap cnt_1", 32'(bus_w.cnt_1), 1);

      // Fill all buffers with consumers stalled, then reset with traffic present
      set_ready(4'b0000);
      for (int k = 0; k < 4; k++) begin
         send(2'(k), 4'(k + 1));
         tick();
      end
      bus.in_valid = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         check($sformatf("fill valid_%0d", k), rd_valid(k), 1);
         check($sformatf("fill data_%0d", k), rd_data(k), 32'(k + 1));
      end
      set_ready(4'b1111);
      send(2'd0, 4'hE);
      rst = 1'b1;
      #1;
      check("mid-rst in_ready", 32'(bus.in_ready), 0);
      tick();
      tick();
      check_all("mid-rst", 0, 0, 0);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      check("after-rst in_ready", 32'(bus.in_ready), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/demux_1_4_buf.md
# demux_1_4_buf

Registered 1-to-4 stream demultiplexer, the inverse of the team's 4:1 index-selected mux. One input stream with a valid/ready handshake and a 2-bit destination index is routed into four independent output streams. Each output stream has its own one-entry buffer and per-channel transfer counter. It sits between a single producer and four consumers that can stall independently; a stall on one channel never blocks traffic to another.

## Interface

Parameters:
- `W`, default 4: data width.
- `CNT_W`, default 8: width of each per-channel transfer counter.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: input word present.
- `in_ready` output 1: block accepts the input word this cycle.
- `in_data` input W: input word.
- `in_sel` input 2: destination channel index, 0..3.
- `out_valid_0..3` output 1 each: channel buffer holds a word.
- `out_ready_0..3` input 1 each: consumer accepts the channel word this cycle.
- `out_data_0..3` output W each: channel buffer contents.
- `cnt_0..3` output CNT_W each: number of words delivered on each channel (output handshakes).

## Operation

- Channel buffer: data register plus full flag; `out_valid_k` equals the full flag of channel k.
- Input handshake: transfer when `in_valid && in_ready`. Output handshake on channel k: transfer when `out_valid_k && out_ready_k`.
- `in_ready = !rst && (!full[in_sel] || out_ready[in_sel])`. This is combinational in `in_sel` and the selected `out_ready`. The buffer accepts when empty, or when full and draining in the same cycle.
- Input transfer to channel k: load `out_data_k <= in_data` and set `full[k] <= 1`.
- Output transfer on channel k with no simultaneous input to k: clear `full[k]`. `out_data_k` keeps its last value.
- Simultaneous input and output transfer on the same channel: reload the data and keep `full[k]` at 1. Back-to-back throughput is 1 word/cycle per channel.
- An output transfer on one channel is independent of an input transfer to another channel in the same cycle.
- Only the indexed channel is touched by an input transfer; the other three buffers are unchanged.
- Counter `cnt_k` increments by 1 on each output transfer of channel k. It wraps from 2^CNT_W−1 to 0 with no saturation and no flag.
- Upstream must hold `in_data` and `in_sel` stable while `in_valid && !in_ready`. The block must not drop or duplicate a word under that rule.
- Once asserted, `out_valid_k` stays high and `out_data_k` stays stable until the output handshake on channel k.

## Timing

- Latency: a word accepted at edge N appears on `out_valid_k` and `out_data_k` after edge N, so it is visible in cycle N+1. There is no combinational path from `in_data` to any `out_data`.
- Reset values, applied at the first rising edge with `rst`=1:
  - all `out_valid_k` = 0
  - all `out_data_k` = 0
  - all `cnt_k` = 0
- `in_ready` = 0 while `rst` is high. It is 1 in the first cycle after reset, because all buffers are empty.
- Reset mid-operation: buffered words are discarded and counters are cleared. Any handshake in a cycle with `rst`=1 is ignored, and no counter increments.
- Full channel with `out_ready_k`=0: `in_ready` is 0 only while `in_sel`=k. If upstream changes `in_sel` on a later cycle while `in_valid` is still held high, that violates the stability rule and the behaviour is unspecified.

## Test plan

- Reset, then send 0x3 to sel 0, 0x5 to sel 1, 0xA to sel 2 and 0xC to sel 3 on consecutive cycles, with all `out_ready`=1.
  - Each `out_valid_k` pulses one cycle after its input with the matching data.
  - Afterwards, `cnt_0..3` = 1.
- Hold `out_ready_2`=0 and send 0x7 to sel 2, then 0x9 to sel 2.
  - 0x7 is buffered.
  - `in_ready`=0 on the second word until `out_ready_2` rises.
  - 0x9 follows 0x7 in order, with no loss.
- With channel 2 full and stalled as above, present 0x1 to sel 0.
  - `in_ready`=1, and 0x1 appears on channel 0 the next cycle. Channel 2 is unaffected.
- Stream 16 words to sel 3 with `out_ready_3`=1 continuously.
  - One word is accepted per cycle, `in_ready` never drops, and `cnt_3`=16.
- With `CNT_W`=4, deliver 17 words on channel 1.
  - `cnt_1` wraps to 1.
- Fill all four buffers with `out_ready`=0, then assert `rst` for one cycle.
  - All `out_valid`=0, all `out_data`=0 and all counters = 0.
  - `in_ready`=1 in the following cycle.
